// File: rtl/pump_pkg.sv
// Shared types and constants for the fill/drain pump sequencer.
package pump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP,
        ST_HOLD,
        ST_RAMP_DOWN,
        ST_DEAD
    } pump_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } pump_owner_e;

    localparam logic [7:0] PWM_MAX = 8'd230;
    localparam logic [7:0] PWM_MIN = 8'd77;

    function automatic logic [7:0] clamp_duty(input logic [7:0] req, input logic [7:0] limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/pwm_slew_limiter.sv
// Duty register that walks toward a target by at most RAMP_STEP per prescaler tick.
module pwm_slew_limiter #(
    parameter logic [7:0]  RAMP_STEP        = 8'd10,
    parameter int unsigned RAMP_TICK_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] target_i,
    input  logic       enable_i,
    input  logic       force_zero_i,
    output logic [7:0] duty_o,
    output logic [7:0] duty_next_o
);

    localparam int CW = (RAMP_TICK_CYCLES > 1) ? $clog2(RAMP_TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(RAMP_TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic          tick;

    // Prescaler sits at zero whenever slewing is paused, so every ramp
    // segment starts a full tick period after it is enabled.
    assign tick = enable_i && (cnt_q == TICK_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!enable_i || force_zero_i || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        duty_d = duty_q;
        if (force_zero_i) begin
            duty_d = '0;
        end else if (tick) begin
            if (target_i > duty_q) begin
                duty_d = ((target_i - duty_q) <= RAMP_STEP) ? target_i : duty_q + RAMP_STEP;
            end else if (target_i < duty_q) begin
                duty_d = ((duty_q - target_i) <= RAMP_STEP) ? target_i : duty_q - RAMP_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            duty_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
        end
    end

    assign duty_o      = duty_q;
    assign duty_next_o = duty_d;

endmodule

// File: rtl/pump_sequencer.sv
// Arbitrates two mutually exclusive pumps, ramps the owner's duty and
// enforces a dead time between any stop and the next start.
module pump_sequencer
    import pump_pkg::*;
#(
    parameter logic [7:0]  RAMP_STEP        = 8'd10,
    parameter int unsigned RAMP_TICK_CYCLES = 50_000,
    parameter int unsigned DEAD_TIME_CYCLES = 25_000_000,
    parameter logic [7:0]  DUTY_LIMIT       = PWM_MAX
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req_duty_a,
    input  logic [7:0] req_duty_b,
    input  logic       estop,
    output logic [7:0] pwm_duty_a,
    output logic [7:0] pwm_duty_b,
    output logic       busy,
    output logic       conflict
);

    localparam int DW = (DEAD_TIME_CYCLES > 1) ? $clog2(DEAD_TIME_CYCLES) : 1;
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME_CYCLES - 1);

    pump_state_e   state_q, state_d;
    pump_owner_e   owner_q, owner_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [7:0]    pwm_a_q, pwm_a_d;
    logic [7:0]    pwm_b_q, pwm_b_d;
    logic          conflict_q;

    logic [7:0]    owner_req;
    logic [7:0]    target;
    logic          slew_en;
    logic [7:0]    duty_q;
    logic [7:0]    duty_d;

    pwm_slew_limiter #(
        .RAMP_STEP        (RAMP_STEP),
        .RAMP_TICK_CYCLES (RAMP_TICK_CYCLES)
    ) u_slew (
        .clk          (clk),
        .reset_n      (reset_n),
        .target_i     (target),
        .enable_i     (slew_en),
        .force_zero_i (estop),
        .duty_o       (duty_q),
        .duty_next_o  (duty_d)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        dead_cnt_d = dead_cnt_q;
        target     = '0;
        slew_en    = 1'b0;
        owner_req  = (owner_q == OWN_A) ? req_duty_a :
                     (owner_q == OWN_B) ? req_duty_b : 8'd0;

        if (estop) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dead_cnt_d = '0;
                    if (req_duty_a != 8'd0) begin
                        owner_d = OWN_A;
                        state_d = ST_RAMP;
                    end else if (req_duty_b != 8'd0) begin
                        owner_d = OWN_B;
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    slew_en = 1'b1;
                    target  = clamp_duty(owner_req, DUTY_LIMIT);
                    if (owner_req == 8'd0) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (duty_q == target) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    target = clamp_duty(owner_req, DUTY_LIMIT);
                    if (owner_req == 8'd0) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (target != duty_q) begin
                        state_d = ST_RAMP;
                    end
                end
                ST_RAMP_DOWN: begin
                    slew_en = 1'b1;
                    if (duty_q == 8'd0) begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = '0;
                    end
                end
                ST_DEAD: begin
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d    = ST_IDLE;
                        owner_d    = OWN_NONE;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            endcase
        end

        // Outputs follow the next duty so a tick shows up on its own edge.
        pwm_a_d = (owner_d == OWN_A) ? duty_d : 8'd0;
        pwm_b_d = (owner_d == OWN_B) ? duty_d : 8'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            dead_cnt_q <= '0;
            pwm_a_q    <= '0;
            pwm_b_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dead_cnt_q <= dead_cnt_d;
            pwm_a_q    <= pwm_a_d;
            pwm_b_q    <= pwm_b_d;
            conflict_q <= (req_duty_a != 8'd0) && (req_duty_b != 8'd0);
        end
    end

    assign pwm_duty_a = pwm_a_q;
    assign pwm_duty_b = pwm_b_q;
    assign busy       = (state_q != ST_IDLE);
    assign conflict   = conflict_q;

endmodule

// File: doc/pump_sequencer.md
PUMP_SEQUENCER -- requirements
Module: pump_sequencer

Interface
REQ-001 Parameter RAMP_STEP, default 8'd10: maximum duty change per ramp tick.
REQ-002 Parameter RAMP_TICK_CYCLES, default 50_000: clock cycles per ramp tick (1 ms @ 50 MHz).
REQ-003 Parameter DEAD_TIME_CYCLES, default 25_000_000: idle gap after any pump stops (0.5 s @ 50 MHz).
REQ-004 Parameter DUTY_LIMIT, default 8'd230: ceiling applied to every request.
REQ-005 The ports SHALL be as follows, one per line:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_duty_a  in  8  requested duty, pump A (fill); 0 = off.
- req_duty_b  in  8  requested duty, pump B (drain); 0 = off.
- estop  in  1  emergency stop, level-sensitive.
- pwm_duty_a  out  8  duty to PWM generator A, registered.
- pwm_duty_b  out  8  duty to PWM generator B, registered.
- busy  out  1  high whenever state != IDLE.
- conflict  out  1  registered; high while both requests are nonzero.

Function
REQ-006 The design SHALL implement the states IDLE, RAMP, HOLD, RAMP_DOWN and DEAD, and SHALL track owner as NONE, A or B.
REQ-007 In IDLE with estop low:
- if req_duty_a != 0, owner = A and go to RAMP;
- else if req_duty_b != 0, owner = B and go to RAMP;
- A wins when both requests are nonzero.
REQ-008 target = min(owner's request, DUTY_LIMIT).
REQ-009 Tick counter:
- cleared on entry to RAMP from IDLE;
- tick pulses when counter == RAMP_TICK_CYCLES-1, then the counter wraps to 0;
- counts only in RAMP and RAMP_DOWN.
REQ-010 On each tick, duty SHALL move toward target by RAMP_STEP; if |target-duty| <= RAMP_STEP, duty = target; no 8-bit wrap in either direction.
REQ-011 RAMP -> HOLD when duty == target; HOLD -> RAMP when target changes to a nonzero value != duty.
REQ-012 In RAMP or HOLD, owner's request == 0 -> RAMP_DOWN (target 0); RAMP_DOWN -> DEAD when duty == 0.
REQ-013 While busy, the non-owner request SHALL be ignored; the owner never changes before IDLE is reached.
REQ-014 DEAD:
- the counter runs DEAD_TIME_CYCLES cycles;
- then go to IDLE with owner = NONE;
- requests present at that point are arbitrated per REQ-007 on the next cycle.
REQ-015 pwm_duty_a = duty if owner == A, else 0; pwm_duty_b = duty if owner == B, else 0; the two SHALL never be nonzero simultaneously.
REQ-016 estop high in any state:
- duty forced to 0 on the next edge (no ramp);
- go to DEAD;
- DEAD count held at 0 while estop stays high.
REQ-017 Output latency: a duty update SHALL appear on the pwm outputs on the same edge that the tick is registered.
REQ-018 conflict SHALL be updated every cycle from the current requests, independent of state.

Reset
REQ-019 reset_n low SHALL asynchronously force:
- state IDLE, owner NONE;
- duty, tick counter and dead counter to 0;
- pwm_duty_a, pwm_duty_b, busy and conflict to 0.
REQ-020 Reset asserted mid-ramp SHALL drop outputs to 0 immediately; after release, the block restarts from IDLE with no dead time.

Structure
REQ-021 Package pump_pkg SHALL hold the state enum, the owner enum (NONE/A/B), PWM_MAX = 8'd230 and PWM_MIN = 8'd77.
REQ-022 The block SHALL contain one sub-module, pwm_slew_limiter, covering the duty register, tick prescaler and step arithmetic with an inputs target/enable/force_zero interface.

Verification
REQ-023 The bench SHALL use RAMP_STEP=10, RAMP_TICK_CYCLES=4, DEAD_TIME_CYCLES=10, DUTY_LIMIT=230 for all scenarios below.
REQ-024 req_duty_a=77 from IDLE -> pwm_duty_a steps 10, 20 ... 70, 77 every 4 cycles; HOLD at 77; pwm_duty_b = 0 throughout.
REQ-025 req_duty_b=255 -> pwm_duty_b ramps to 230 and holds there, never exceeding it; then req_duty_b=0 -> ramps 230, 220 ... 0 -> DEAD for 10 cycles -> IDLE, busy falls.
REQ-026 A owns at 230 while req_duty_b=230 asserts -> conflict = 1, pwm_duty_b stays 0; A releases -> ramp down, 10 dead cycles, then B ramps from 10.
REQ-027 estop pulse at duty 150 -> pwm outputs 0 on the next edge; DEAD lasts 10 cycles after estop falls.
REQ-028 reset_n low mid-ramp at duty 40 -> all outputs 0 without waiting for a clock edge; after release with req_duty_a=77 -> RAMP entered on the next edge.
